// File: rtl/chime_sequencer_pkg.sv
// Shared definitions for the chime sequencer: sequencer state encoding,
// BCD hour limits and the hour-to-strike-count decode.
// Optional build macro: HOUR12_EN selects 12-hour strike counts.
package media_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHIME_ON  = 3'd1,
        ST_CHIME_GAP = 3'd2,
        ST_ALARM_ON  = 3'd3,
        ST_ALARM_GAP = 3'd4
    } state_e;

    localparam logic [3:0] HOUR_TENS_MAX = 4'd2;
    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam logic [5:0] HOUR_MAX      = 6'd23;

    // Number of strike beeps for a BCD hour; 0 means "no strike"
    // (either an invalid BCD value or an hour that does not chime).
    function automatic logic [5:0] bcd_hour_to_count(input logic [3:0] tens,
                                                     input logic [3:0] units);
        logic [5:0] hour;
        logic [5:0] count;
        hour = 6'(tens) * 6'd10 + 6'(units);
        if ((tens > HOUR_TENS_MAX) || (units > BCD_DIGIT_MAX) || (hour > HOUR_MAX)) begin
            count = 6'd0;
        end
`ifdef HOUR12_EN
        else if (hour == 6'd0) begin
            count = 6'd12;
        end
        else if (hour > 6'd12) begin
            count = hour - 6'd12;
        end
`endif
        else begin
            count = hour;
        end
        return count;
    endfunction

endpackage

// File: rtl/chime_sequencer_tone_gen.sv
// Square-wave tone divider. The output toggles every TONE_DIV cycles while
// enabled; restart forces the output high and realigns the divider so each
// beep starts on a high half-period. Disabled means a silent (low) output.
module tone_gen #(
    parameter int unsigned TONE_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic tone
);

    localparam int DW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    logic [DW-1:0] div_r;
    logic          tone_r;

    // Divider and tone output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r  <= DW'(0);
            tone_r <= 1'b0;
        end else if (!enable) begin
            div_r  <= DW'(0);
            tone_r <= 1'b0;
        end else if (restart) begin
            div_r  <= DW'(0);
            tone_r <= 1'b1;
        end else if (div_r == DW'(TONE_DIV - 1)) begin
            div_r  <= DW'(0);
            tone_r <= ~tone_r;
        end else begin
            div_r  <= div_r + DW'(1);
            tone_r <= tone_r;
        end
    end

    assign tone = tone_r;

endmodule

// File: rtl/chime_sequencer.sv
// Chime sequencer: turns the hourly strike pulse and the alarm pulse into a
// gated square-wave buzzer drive. An alarm preempts a strike; a strike never
// preempts an alarm. Optional build macro: HOUR12_EN (12-hour strike counts).
module chime_sequencer
    import media_pkg::*;
#(
    parameter int unsigned TONE_DIV    = 4,
    parameter int unsigned BEEP_ON     = 16,
    parameter int unsigned BEEP_GAP    = 8,
    parameter int unsigned ALARM_BEEPS = 60,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        on_the_hour,
    input  logic        on_alarm,
    input  logic        alarm_stop,
    input  logic [23:0] clock_time,
    output logic        audio,
    output logic        busy,
    output logic        alarm_active,
    output logic [5:0]  beeps_left
);

    localparam int AW = $clog2(ALARM_BEEPS + 1);

    state_e           state_r, state_s;
    logic [CNT_W-1:0] phase_r, phase_s;
    logic [5:0]       beeps_r, beeps_s;
    logic [AW-1:0]    acnt_r, acnt_s;
    logic             restart_s;
    logic             tone_en_s;
    logic             busy_r;
    logic             alarm_active_r;
    logic [5:0]       strike_s;
    logic [AW-1:0]    acnt_eff_s;
    logic             on_end_s;
    logic             gap_end_s;
    logic             unused_time_s;

    assign strike_s      = bcd_hour_to_count(clock_time[23:20], clock_time[19:16]);
    assign unused_time_s = ^clock_time[15:0];
    assign on_end_s      = (phase_r == CNT_W'(BEEP_ON - 1));
    assign gap_end_s     = (phase_r == CNT_W'(BEEP_GAP - 1));
    assign acnt_eff_s    = on_alarm ? AW'(ALARM_BEEPS) : acnt_r;

    // Next-state, phase, strike count and alarm count decode.
    always_comb begin
        state_s   = state_r;
        phase_s   = phase_r;
        beeps_s   = beeps_r;
        acnt_s    = acnt_r;
        restart_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                phase_s = CNT_W'(0);
                if (on_alarm) begin
                    state_s   = ST_ALARM_ON;
                    acnt_s    = AW'(ALARM_BEEPS);
                    beeps_s   = 6'd0;
                    restart_s = 1'b1;
                end else if (on_the_hour && (strike_s != 6'd0)) begin
                    state_s   = ST_CHIME_ON;
                    beeps_s   = strike_s;
                    restart_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CHIME_ON, ST_CHIME_GAP: begin
                if (on_alarm) begin
                    state_s   = ST_ALARM_ON;
                    phase_s   = CNT_W'(0);
                    beeps_s   = 6'd0;
                    acnt_s    = AW'(ALARM_BEEPS);
                    restart_s = 1'b1;
                end else if ((state_r == ST_CHIME_ON) && on_end_s) begin
                    state_s = ST_CHIME_GAP;
                    phase_s = CNT_W'(0);
                    beeps_s = beeps_r - 6'd1;
                end else if ((state_r == ST_CHIME_GAP) && gap_end_s) begin
                    phase_s = CNT_W'(0);
                    if (beeps_r != 6'd0) begin
                        state_s   = ST_CHIME_ON;
                        restart_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    phase_s = phase_r + CNT_W'(1);
                end
            end
            ST_ALARM_ON, ST_ALARM_GAP: begin
                if (alarm_stop) begin
                    state_s = ST_IDLE;
                    phase_s = CNT_W'(0);
                    acnt_s  = AW'(0);
                end else if ((state_r == ST_ALARM_ON) && on_end_s) begin
                    state_s = ST_ALARM_GAP;
                    phase_s = CNT_W'(0);
                    acnt_s  = on_alarm ? AW'(ALARM_BEEPS) : (acnt_r - AW'(1));
                end else if ((state_r == ST_ALARM_GAP) && gap_end_s) begin
                    phase_s = CNT_W'(0);
                    acnt_s  = acnt_eff_s;
                    if (acnt_eff_s != AW'(0)) begin
                        state_s   = ST_ALARM_ON;
                        restart_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    phase_s = phase_r + CNT_W'(1);
                    acnt_s  = acnt_eff_s;
                end
            end
            default: begin
                state_s = ST_IDLE;
                phase_s = CNT_W'(0);
                beeps_s = 6'd0;
                acnt_s  = AW'(0);
            end
        endcase
    end

    assign tone_en_s = (state_s == ST_CHIME_ON) || (state_s == ST_ALARM_ON);

    // Sequencer state, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            phase_r        <= CNT_W'(0);
            beeps_r        <= 6'd0;
            acnt_r         <= AW'(0);
            busy_r         <= 1'b0;
            alarm_active_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            phase_r        <= phase_s;
            beeps_r        <= beeps_s;
            acnt_r         <= acnt_s;
            busy_r         <= (state_s != ST_IDLE);
            alarm_active_r <= (state_s == ST_ALARM_ON) || (state_s == ST_ALARM_GAP);
        end
    end

    tone_gen #(
        .TONE_DIV (TONE_DIV)
    ) u_tone (
        .clk     (clk),
        .rst     (rst),
        .enable  (tone_en_s),
        .restart (restart_s),
        .tone    (audio)
    );

    assign busy         = busy_r;
    assign alarm_active = alarm_active_r;
    assign beeps_left   = beeps_r;

endmodule

// File: tb/tb_chime_sequencer.sv
// Self-checking bench for chime_sequencer: directed scenarios followed by
// randomized pulses, all compared cycle by cycle against a beep-schedule model.
module tb_chime_sequencer;

    localparam int TONE_DIV    = 2;
    localparam int BEEP_ON     = 8;
    localparam int BEEP_GAP    = 4;
    localparam int ALARM_BEEPS = 5;
    localparam int PERIOD      = BEEP_ON + BEEP_GAP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        on_the_hour = 1'b0;
    logic        on_alarm = 1'b0;
    logic        alarm_stop = 1'b0;
    logic [23:0] clock_time = 24'h000000;
    logic        audio;
    logic        busy;
    logic        alarm_active;
    logic [5:0]  beeps_left;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 chime, 2 alarm; t = cycle offset in the beep period.
    int m_mode = 0;
    int m_t    = 0;
    int m_cl   = 0;
    int m_al   = 0;

    chime_sequencer #(
        .TONE_DIV    (TONE_DIV),
        .BEEP_ON     (BEEP_ON),
        .BEEP_GAP    (BEEP_GAP),
        .ALARM_BEEPS (ALARM_BEEPS),
        .CNT_W       (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .on_the_hour  (on_the_hour),
        .on_alarm     (on_alarm),
        .alarm_stop   (alarm_stop),
        .clock_time   (clock_time),
        .audio        (audio),
        .busy         (busy),
        .alarm_active (alarm_active),
        .beeps_left   (beeps_left)
    );

    always #5 clk = ~clk;

    function automatic int strike_count(input logic [23:0] ct);
        int tens, units, h;
        tens  = int'(ct[23:20]);
        units = int'(ct[19:16]);
        if (tens > 2 || units > 9) return 0;
        h = tens * 10 + units;
        if (h > 23) return 0;
`ifdef HOUR12_EN
        if (h == 0) return 12;
        if (h > 12) return h - 12;
`endif
        return h;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_mode = 0; m_t = 0; m_cl = 0; m_al = 0;
        end else if (m_mode == 0) begin
            if (on_alarm) begin
                m_mode = 2; m_t = 0; m_al = ALARM_BEEPS; m_cl = 0;
            end else if (on_the_hour && strike_count(clock_time) > 0) begin
                m_mode = 1; m_t = 0; m_cl = strike_count(clock_time);
            end
        end else if (m_mode == 1) begin
            if (on_alarm) begin
                m_mode = 2; m_t = 0; m_al = ALARM_BEEPS; m_cl = 0;
            end else begin
                m_t++;
                if (m_t == BEEP_ON) m_cl--;
                if (m_t == PERIOD) begin
                    if (m_cl > 0) m_t = 0;
                    else m_mode = 0;
                end
            end
        end else begin
            if (alarm_stop) begin
                m_mode = 0; m_t = 0; m_al = 0;
            end else begin
                m_t++;
                if (m_t == BEEP_ON) m_al--;
                if (on_alarm) m_al = ALARM_BEEPS;
                if (m_t == PERIOD) begin
                    if (m_al > 0) m_t = 0;
                    else begin m_mode = 0; m_al = 0; end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance model and compare all outputs.
    task automatic tick(input logic r, input logic oh, input logic oa, input logic st);
        int exp_audio;
        rst = r; on_the_hour = oh; on_alarm = oa; alarm_stop = st;
        @(posedge clk);
        model_step();
        #1;
        exp_audio = (m_mode != 0 && m_t < BEEP_ON && ((m_t / TONE_DIV) % 2) == 0) ? 1 : 0;
        chk("audio", 32'(audio), 32'(exp_audio));
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("alarm_active", 32'(alarm_active), 32'(m_mode == 2));
        chk("beeps_left", 32'(beeps_left), 32'((m_mode == 1) ? m_cl : 0));
        rst = 1'b0; on_the_hour = 1'b0; on_alarm = 1'b0; alarm_stop = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2;
        // Reset state
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        idle_ticks(2);

        // 3 o'clock strike: 3 beeps, busy for 36 cycles
        clock_time = 24'h030000;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        idle_ticks(40);
        chk("busy_after_strike3", 32'(busy), 32'd0);

        // Midnight and 15h strikes
        clock_time = 24'h000000;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        idle_ticks(12 * PERIOD + 4);
        clock_time = 24'h150000;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        idle_ticks(15 * PERIOD + 4);

        // Alarm without stop: 5 beeps
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        idle_ticks(ALARM_BEEPS * PERIOD + 4);
        chk("alarm_self_end", 32'(alarm_active), 32'd0);

        // Alarm, stop on cycle 10
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        idle_ticks(9);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("stop_audio", 32'(audio), 32'd0);
        idle_ticks(3);

        // Chime of 12 preempted by alarm during beep 4; strike during alarm ignored
        clock_time = 24'h120000;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        idle_ticks(3 * PERIOD + 3);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("preempt_audio", 32'(audio), 32'd1);
        chk("preempt_beeps", 32'(beeps_left), 32'd0);
        idle_ticks(5);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        idle_ticks(20);
        tick(1'b0, 1'b0, 1'b1, 1'b0);   // reload mid-alarm
        idle_ticks(ALARM_BEEPS * PERIOD + 6);

        // Simultaneous pulses start alarm only
        clock_time = 24'h070000;
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        idle_ticks(6);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        idle_ticks(2);

        // Invalid BCD strikes
        clock_time = 24'h2A0000;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        clock_time = 24'h250000;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        clock_time = 24'h3F0000;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        idle_ticks(2);

        // Reset mid-beep
        clock_time = 24'h090000;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        idle_ticks(3);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_audio", 32'(audio), 32'd0);
        idle_ticks(2);

        // Randomized pulses
        for (int i = 0; i < 3000; i++) begin
            logic oh, oa, st, r;
            clock_time = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 11)), 16'($urandom)};
            oh = ($urandom_range(0, 39) == 0);
            oa = ($urandom_range(0, 89) == 0);
            st = ($urandom_range(0, 39) == 0);
            r  = ($urandom_range(0, 599) == 0);
            tick(r, oh, oa, st);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
